alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream presents an instruction with its operands.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 in_instr  input  32  RV32 instruction word.
REQ-007 in_rs1_val  input  32  value of register rs1.
REQ-008 in_rs2_val  input  32  value of register rs2.
REQ-009 out_valid  output  1  head entry valid for the ALU.
REQ-010 out_ready  input  1  downstream consumes the head entry.
REQ-011 out_opcode  output  5  ALU operation code.
REQ-012 out_a  output  32  ALU operand A.
REQ-013 out_b  output  32  ALU operand B.
REQ-014 out_rd  output  5  destination register, taken from in_instr[11:7].
REQ-015 out_illegal  output  1  head entry was not a supported instruction.
REQ-016 illegal_count  output  8  saturating count of illegal instructions popped.

Function
REQ-017 Input handshake: transfer occurs when in_valid and in_ready are both 1.
REQ-018 Output handshake: transfer occurs when out_valid and out_ready are both 1.
REQ-019 Storage: 2-entry FIFO with an occupancy count of 0..2; in_ready = (count < 2).
REQ-020 Output fields come from the head entry; out_valid = (count > 0).
REQ-021 Latency: an instruction accepted in cycle N is visible on out_valid in cycle N+1 at the earliest. There is no combinational path from input to output.
REQ-022 Push and pop in the same cycle keep count unchanged and preserve FIFO order.
REQ-023 A pop while count == 0 is ignored. A push is impossible while count == 2 because in_ready is 0.
REQ-024 Output fields are held stable while out_valid = 1 and out_ready = 0.
REQ-025 Decode is done at push time and the decoded fields are stored in the FIFO.
REQ-026 OP instructions (in_instr[6:0] = 0110011), with a = rs1 and b = rs2:
  - funct7 0000000: funct3 0..7 map to ADD 00100, SLL 00110, SLT 10100, SLTU 10101, XOR 10010, SRL 00111, OR 10001, AND 10011.
  - funct7 0100000: funct3 0 maps to SUB 00101; funct3 5 maps to SRA 01000.
  - funct7 0000001: funct3 0..7 map to MUL 01001, MULH 01010, MULHSU 01100, MULHU 01011, DIV 01101, DIVU 01110, REM 01111, REMU 10000.
REQ-027 OP-IMM instructions (0010011), with a = rs1 and b = sign-extended in_instr[31:20]:
  - funct3 0 ADDI 00100, 2 SLTI 10100, 3 SLTIU 10101, 4 XORI 10010, 6 ORI 10001, 7 ANDI 10011.
REQ-028 OP-IMM shifts, with b = zero-extended in_instr[24:20]:
  - SLLI: funct3 1, in_instr[31:25] = 0000000, opcode 00110.
  - SRLI: funct3 5, in_instr[31:25] = 0000000, opcode 00111.
  - SRAI: funct3 5, in_instr[31:25] = 0100000, opcode 01000.
REQ-029 LUI (0110111): opcode 00001, a = {in_instr[31:12], 12'b0}, b = 0.
REQ-030 Illegal instructions:
  - Covers any other encoding, including OP or OP-IMM with an unlisted funct7 or funct3/funct7 combination.
  - Outputs: opcode 00000, a = 0, b = 0, illegal = 1, rd = in_instr[11:7].
  - An illegal instruction still occupies a FIFO entry.
REQ-031 illegal_count increments on each popped entry with illegal = 1 and saturates at 255.
REQ-032 rd = 0 is not special; the entry is issued normally.

Reset
REQ-033 While rst_n = 0: count = 0, out_valid = 0, in_ready = 0, out_opcode = 0, out_a = 0, out_b = 0, out_rd = 0, out_illegal = 0, illegal_count = 0.
REQ-034 in_ready rises in the first cycle after rst_n deasserts.
REQ-035 Reset asserted mid-operation discards all FIFO entries immediately, without waiting for a clock edge.

Verification
REQ-036 ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, out_ready = 1 -> next cycle: out_valid = 1, opcode 00100, a = 5, b = 7, rd = 3.
REQ-037 ADDI x1,x0,-1 (0xFFF00093), rs1 = 0 -> opcode 00100, a = 0, b = 0xFFFFFFFF, rd = 1.
REQ-038 Backpressure:
  - Stimulus: out_ready = 0 with 3 instructions offered.
  - Response: two are accepted, in_ready = 0 after the second, head is held stable.
  - Then out_ready = 1: entries drain in order and in_ready returns to 1.
REQ-039 SRAI x2,x2,4 (0x40415113) -> opcode 01000, b = 4. DIVU (funct7 0000001, funct3 5) -> opcode 01110.
REQ-040 Illegal word 0xFFFFFFFF popped 300 times -> each pop shows opcode 00000 and illegal = 1; illegal_count ends at 255.
REQ-041 rst_n pulsed low while count = 2 -> out_valid = 0 and count = 0 at once; after release, in_ready = 1 on the first clock.

Source files
------------

// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32I/M integer instructions at push time and
// buffers the decoded operation in a 2-entry FIFO that feeds the ALU.
module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_opcode,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_illegal,
   output logic [7:0]      illegal_count
);

   localparam logic [6:0] MAJ_OP     = 7'b0110011;
   localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
   localparam logic [6:0] MAJ_LUI    = 7'b0110111;

   logic [4:0]      entOpcode_q  [2];
   logic [XLEN-1:0] entA_q       [2];
   logic [XLEN-1:0] entB_q       [2];
   logic [4:0]      entRd_q      [2];
   logic            entIllegal_q [2];

   logic       head_q, head_d;
   logic       tail_q, tail_d;
   logic [1:0] count_q, count_d;
   logic [7:0] illCnt_q, illCnt_d;
   logic       initDone_q;

   logic [4:0]      decOpcode;
   logic [XLEN-1:0] decA;
   logic [XLEN-1:0] decB;
   logic            decLegal;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            push;
   logic            pop;

   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // in_ready is held low until the first clock after reset releases
   assign in_ready  = initDone_q && (count_q < 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_opcode    = entOpcode_q[head_q];
   assign out_a         = entA_q[head_q];
   assign out_b         = entB_q[head_q];
   assign out_rd        = entRd_q[head_q];
   assign out_illegal   = entIllegal_q[head_q];
   assign illegal_count = illCnt_q;

   // Decode the incoming word into ALU opcode and operands; anything not listed is illegal
   always_comb begin
      decOpcode = 5'b00000;
      decA      = '0;
      decB      = '0;
      decLegal  = 1'b0;
      case (in_instr[6:0])
         MAJ_OP: begin
            decA = in_rs1_val;
            decB = in_rs2_val;
            case (funct7)
               7'b0000000: begin
                  decLegal = 1'b1;
                  case (funct3)
                     3'd0: decOpcode = 5'b00100;
                     3'd1: decOpcode = 5'b00110;
                     3'd2: decOpcode = 5'b10100;
                     3'd3: decOpcode = 5'b10101;
                     3'd4: decOpcode = 5'b10010;
                     3'd5: decOpcode = 5'b00111;
                     3'd6: decOpcode = 5'b10001;
                     default: decOpcode = 5'b10011;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'd0) begin
                     decLegal  = 1'b1;
                     decOpcode = 5'b00101;
                  end else if (funct3 == 3'd5) begin
                     decLegal  = 1'b1;
                     decOpcode = 5'b01000;
                  end
               end
               7'b0000001: begin
                  decLegal = 1'b1;
                  case (funct3)
                     3'd0: decOpcode = 5'b01001;
                     3'd1: decOpcode = 5'b01010;
                     3'd2: decOpcode = 5'b01100;
                     3'd3: decOpcode = 5'b01011;
                     3'd4: decOpcode = 5'b01101;
                     3'd5: decOpcode = 5'b01110;
                     3'd6: decOpcode = 5'b01111;
                     default: decOpcode = 5'b10000;
                  endcase
               end
               default: ;
            endcase
         end
         MAJ_OP_IMM: begin
            decA = in_rs1_val;
            decB = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            case (funct3)
               3'd0: begin decLegal = 1'b1; decOpcode = 5'b00100; end
               3'd2: begin decLegal = 1'b1; decOpcode = 5'b10100; end
               3'd3: begin decLegal = 1'b1; decOpcode = 5'b10101; end
               3'd4: begin decLegal = 1'b1; decOpcode = 5'b10010; end
               3'd6: begin decLegal = 1'b1; decOpcode = 5'b10001; end
               3'd7: begin decLegal = 1'b1; decOpcode = 5'b10011; end
               3'd1: begin
                  decB = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                  if (funct7 == 7'b0000000) begin
                     decLegal  = 1'b1;
                     decOpcode = 5'b00110;
                  end
               end
               default: begin
                  decB = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                  if (funct7 == 7'b0000000) begin
                     decLegal  = 1'b1;
                     decOpcode = 5'b00111;
                  end else if (funct7 == 7'b0100000) begin
                     decLegal  = 1'b1;
                     decOpcode = 5'b01000;
                  end
               end
            endcase
         end
         MAJ_LUI: begin
            decLegal  = 1'b1;
            decOpcode = 5'b00001;
            decA      = {in_instr[31:12], 12'b0};
            decB      = '0;
         end
         default: ;
      endcase
      if (!decLegal) begin
         decOpcode = 5'b00000;
         decA      = '0;
         decB      = '0;
      end
   end

   // Next-state for FIFO pointers, occupancy and the saturating illegal counter
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      illCnt_d = illCnt_q;
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (pop && entIllegal_q[head_q] && (illCnt_q != 8'hFF)) illCnt_d = illCnt_q + 8'd1;
   end

   // State registers; reset clears every entry so the head outputs read zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         count_q    <= 2'd0;
         illCnt_q   <= 8'd0;
         initDone_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            entOpcode_q[i]  <= 5'b00000;
            entA_q[i]       <= '0;
            entB_q[i]       <= '0;
            entRd_q[i]      <= 5'b00000;
            entIllegal_q[i] <= 1'b0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         illCnt_q   <= illCnt_d;
         initDone_q <= 1'b1;
         if (push) begin
            entOpcode_q[tail_q]  <= decOpcode;
            entA_q[tail_q]       <= decA;
            entB_q[tail_q]       <= decB;
            entRd_q[tail_q]      <= in_instr[11:7];
            entIllegal_q[tail_q] <= !decLegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_opcode;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_illegal;
   logic [7:0]  illegal_count;

   int checks;
   int failures;
   int expIll;
   logic [75:0] got;
   logic [75:0] exp;

   alu_issue #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b),
      .out_rd(out_rd), .out_illegal(out_illegal), .illegal_count(illegal_count)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Offer one instruction for a single cycle; returns on the following negedge
   task automatic pushOne(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
      @(negedge clk);
      in_valid   = 1'b1;
      in_instr   = instr;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_instr = 32'h0;
      in_rs1_val = 32'h0;
      in_rs2_val = 32'h0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_opcode, out_a, out_b, out_rd, out_illegal, illegal_count} !== 84'h0) begin
         failures++;
         $display("[TB] FAIL reset_state got rdy=%b vld=%b op=%b a=%h b=%h rd=%0d ill=%b cnt=%0d exp all zero",
                  in_ready, out_valid, out_opcode, out_a, out_b, out_rd, out_illegal, illegal_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_add;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 32'd5; in_rs2_val = 32'd7;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_no_comb_path got vld=%b exp 0", out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      got = {out_valid, out_opcode, out_a, out_b, out_rd, out_illegal};
      exp = {1'b1, 5'b00100, 32'd5, 32'd7, 5'd3, 1'b0};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL add_fields got=%h exp=%h", got, exp);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL add_drained got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_addi;
      out_ready = 1'b1;
      pushOne(32'hFFF00093, 32'd0, 32'hDEADBEEF);
      got = {out_valid, out_opcode, out_a, out_b, out_rd, out_illegal};
      exp = {1'b1, 5'b00100, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL addi_fields got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_decode;
      logic [31:0] vInstr [12];
      logic [4:0]  vOp    [12];
      logic [31:0] vA     [12];
      logic [31:0] vB     [12];
      logic [4:0]  vRd    [12];
      logic        vIll   [12];
      // SRAI x2,x2,4
      vInstr[0]  = 32'h40415113; vOp[0]  = 5'b01000; vA[0]  = 32'h11111111; vB[0]  = 32'd4;          vRd[0]  = 5'd2; vIll[0]  = 1'b0;
      // DIVU x3,x1,x2
      vInstr[1]  = 32'h0220D1B3; vOp[1]  = 5'b01110; vA[1]  = 32'h11111111; vB[1]  = 32'h22222222; vRd[1]  = 5'd3; vIll[1]  = 1'b0;
      // SUB x3,x1,x2
      vInstr[2]  = 32'h402081B3; vOp[2]  = 5'b00101; vA[2]  = 32'h11111111; vB[2]  = 32'h22222222; vRd[2]  = 5'd3; vIll[2]  = 1'b0;
      // SLTU x3,x1,x2
      vInstr[3]  = 32'h0020B1B3; vOp[3]  = 5'b10101; vA[3]  = 32'h11111111; vB[3]  = 32'h22222222; vRd[3]  = 5'd3; vIll[3]  = 1'b0;
      // LUI x5,0x12345
      vInstr[4]  = 32'h123452B7; vOp[4]  = 5'b00001; vA[4]  = 32'h12345000; vB[4]  = 32'h0;        vRd[4]  = 5'd5; vIll[4]  = 1'b0;
      // SLLI x1,x1,31
      vInstr[5]  = 32'h01F09093; vOp[5]  = 5'b00110; vA[5]  = 32'h11111111; vB[5]  = 32'd31;       vRd[5]  = 5'd1; vIll[5]  = 1'b0;
      // ANDI x4,x1,0x7FF
      vInstr[6]  = 32'h7FF0F213; vOp[6]  = 5'b10011; vA[6]  = 32'h11111111; vB[6]  = 32'h7FF;      vRd[6]  = 5'd4; vIll[6]  = 1'b0;
      // OP funct7=0100000 funct3=1 is not listed
      vInstr[7]  = 32'h402091B3; vOp[7]  = 5'b00000; vA[7]  = 32'h0;        vB[7]  = 32'h0;        vRd[7]  = 5'd3; vIll[7]  = 1'b1;
      // SLLI with funct7=0100000 is not listed
      vInstr[8]  = 32'h40109093; vOp[8]  = 5'b00000; vA[8]  = 32'h0;        vB[8]  = 32'h0;        vRd[8]  = 5'd1; vIll[8]  = 1'b1;
      // MULHU x3,x1,x2
      vInstr[9]  = 32'h0220B1B3; vOp[9]  = 5'b01011; vA[9]  = 32'h11111111; vB[9]  = 32'h22222222; vRd[9]  = 5'd3; vIll[9]  = 1'b0;
      // ADD x0,x1,x2 issues normally
      vInstr[10] = 32'h00208033; vOp[10] = 5'b00100; vA[10] = 32'h11111111; vB[10] = 32'h22222222; vRd[10] = 5'd0; vIll[10] = 1'b0;
      // OR x3,x1,x2
      vInstr[11] = 32'h0020E1B3; vOp[11] = 5'b10001; vA[11] = 32'h11111111; vB[11] = 32'h22222222; vRd[11] = 5'd3; vIll[11] = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         pushOne(vInstr[i], 32'h11111111, 32'h22222222);
         got = {out_valid, out_opcode, out_a, out_b, out_rd, out_illegal};
         exp = {1'b1, vOp[i], vA[i], vB[i], vRd[i], vIll[i]};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL decode_%0d instr=%h got=%h exp=%h", i, vInstr[i], got, exp);
         end
         if (vIll[i]) expIll++;
      end
      @(negedge clk);
      checks++;
      if ({out_valid, illegal_count} !== {1'b0, expIll[7:0]}) begin
         failures++;
         $display("[TB] FAIL decode_illcount got vld=%b cnt=%0d exp vld=0 cnt=%0d", out_valid, illegal_count, expIll);
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 32'd1; in_rs2_val = 32'd2;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_a} !== {2'b11, 32'd1}) begin
         failures++;
         $display("[TB] FAIL bp_first got vld=%b rdy=%b a=%0d exp vld=1 rdy=1 a=1", out_valid, in_ready, out_a);
      end
      in_rs1_val = 32'd3; in_rs2_val = 32'd4;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_a, out_b} !== {2'b10, 32'd1, 32'd2}) begin
         failures++;
         $display("[TB] FAIL bp_full got vld=%b rdy=%b a=%0d b=%0d exp vld=1 rdy=0 a=1 b=2", out_valid, in_ready, out_a, out_b);
      end
      in_rs1_val = 32'd5; in_rs2_val = 32'd6;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_a, out_b, out_opcode} !== {2'b10, 32'd1, 32'd2, 5'b00100}) begin
         failures++;
         $display("[TB] FAIL bp_hold got vld=%b rdy=%b a=%0d b=%0d op=%b exp vld=1 rdy=0 a=1 b=2 op=00100",
                  out_valid, in_ready, out_a, out_b, out_opcode);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_a, out_b} !== {2'b11, 32'd3, 32'd4}) begin
         failures++;
         $display("[TB] FAIL bp_drain_second got vld=%b rdy=%b a=%0d b=%0d exp vld=1 rdy=1 a=3 b=4", out_valid, in_ready, out_a, out_b);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_a, out_b} !== {1'b1, 32'd5, 32'd6}) begin
         failures++;
         $display("[TB] FAIL bp_drain_third got vld=%b a=%0d b=%0d exp vld=1 a=5 b=6", out_valid, out_a, out_b);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL bp_empty got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_illegal_saturation;
      int want;
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         pushOne(32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0);
         want = (expIll > 255) ? 255 : expIll;
         checks++;
         if ({out_valid, out_opcode, out_illegal, out_a, out_b, illegal_count} !== {1'b1, 5'b00000, 1'b1, 64'h0, want[7:0]}) begin
            failures++;
            $display("[TB] FAIL illegal_pop_%0d got vld=%b op=%b ill=%b a=%h b=%h cnt=%0d exp vld=1 op=00000 ill=1 a=0 b=0 cnt=%0d",
                     i, out_valid, out_opcode, out_illegal, out_a, out_b, illegal_count, want);
         end
         expIll++;
      end
      @(negedge clk);
      checks++;
      if (illegal_count !== 8'd255) begin
         failures++;
         $display("[TB] FAIL illegal_saturated got cnt=%0d exp 255", illegal_count);
      end
   endtask

   task automatic test_reset_midop;
      out_ready = 1'b0;
      pushOne(32'h002081B3, 32'd9, 32'd10);
      pushOne(32'h123452B7, 32'd0, 32'd0);
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL midop_full got vld=%b rdy=%b exp vld=1 rdy=0", out_valid, in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      expIll = 0;
      checks++;
      if ({out_valid, in_ready, out_opcode, out_a, out_b, out_rd, out_illegal, illegal_count} !== 83'h0) begin
         failures++;
         $display("[TB] FAIL midop_async_clear got vld=%b rdy=%b op=%b a=%h b=%h rd=%0d ill=%b cnt=%0d exp all zero",
                  out_valid, in_ready, out_opcode, out_a, out_b, out_rd, out_illegal, illegal_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL midop_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   // Run each scenario in order, then report
   initial begin
      checks = 0;
      failures = 0;
      expIll = 0;
      test_reset();
      test_add();
      test_addi();
      test_decode();
      test_backpressure();
      test_illegal_saturation();
      test_reset_midop();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
